// File: rtl/winograd_tile_scheduler_if.sv
// winograd_tile_scheduler_if
//   Bundles the tile-issue bus between the image/transform side and the
//   per-tile Winograd engine.
//   master : the scheduler (drives tile_data/row/col/valid/last, image_lock,
//            busy, done; receives start, tile_in, tile_ready)
//   slave  : the environment (drives start, tile_in, tile_ready)
interface winograd_tile_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TILES_R    = 3,
  parameter int TILES_C    = 3,
  parameter int TILE       = 6
);
  localparam int ROW_W = (TILES_R > 1) ? $clog2(TILES_R) : 1;
  localparam int COL_W = (TILES_C > 1) ? $clog2(TILES_C) : 1;

  logic                                                           start;
  logic [TILES_R-1:0][TILES_C-1:0][TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] tile_in;
  logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0]                      tile_data;
  logic [ROW_W-1:0]                                               tile_row;
  logic [COL_W-1:0]                                               tile_col;
  logic                                                           tile_valid;
  logic                                                           tile_ready;
  logic                                                           tile_last;
  logic                                                           image_lock;
  logic                                                           busy;
  logic                                                           done;

  modport master (
    input  start, tile_in, tile_ready,
    output tile_data, tile_row, tile_col, tile_valid, tile_last,
           image_lock, busy, done
  );

  modport slave (
    output start, tile_in, tile_ready,
    input  tile_data, tile_row, tile_col, tile_valid, tile_last,
           image_lock, busy, done
  );
endinterface

// File: rtl/winograd_tile_scheduler.sv
// winograd_tile_scheduler
//   Walks the TILES_R x TILES_C grid of Winograd input tiles in row-major
//   order and offers them one at a time over a valid/ready handshake. While
//   a frame is in flight the image source is told to hold the image stable;
//   a one-cycle done pulse follows acceptance of the final tile.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : winograd_tile_scheduler_if.master (start, tile_in, tile_ready in;
//          tile_data/row/col/valid/last, image_lock, busy, done out)
module winograd_tile_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int TILES_R    = 3,
  parameter int TILES_C    = 3,
  parameter int TILE       = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  winograd_tile_scheduler_if.master     bus
);
  localparam int ROW_W = (TILES_R > 1) ? $clog2(TILES_R) : 1;
  localparam int COL_W = (TILES_C > 1) ? $clog2(TILES_C) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILES_R - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(TILES_C - 1);

  typedef logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] tile_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  tile_t            tile_data_q, tile_data_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  logic tile_valid;
  logic last_tile;

  // The offer is valid exactly while in SEND, so valid, busy and the image
  // lock all derive from the registered state and never glitch.
  assign tile_valid = (state_q == S_SEND);
  assign last_tile  = tile_valid && (row_q == LAST_ROW) && (col_q == LAST_COL);

  // State and offered-tile registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tile_data_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      tile_data_q <= tile_data_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  // Next-state logic. The tile register only loads on start or on an
  // accepted non-last beat, which keeps tile_data frozen during backpressure.
  // The new grid position is computed first so the matching tile is
  // captured on the same edge that advances the position.
  always_comb begin
    state_d     = state_q;
    tile_data_d = tile_data_q;
    row_d       = row_q;
    col_d       = col_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d       = '0;
          col_d       = '0;
          tile_data_d = bus.tile_in[0][0];
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.tile_ready) begin
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            tile_data_d = bus.tile_in[row_d][col_d];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.tile_data  = tile_data_q;
  assign bus.tile_row   = row_q;
  assign bus.tile_col   = col_q;
  assign bus.tile_valid = tile_valid;
  assign bus.tile_last  = last_tile;
  assign bus.image_lock = tile_valid;
  assign bus.busy       = tile_valid;
  assign bus.done       = (state_q == S_DONE);
endmodule

// File: doc/winograd_tile_scheduler.md
# winograd_tile_scheduler

Sequential controller that walks the 3x3 grid of 6x6 Winograd input tiles produced by `transform_10x12_3x3x6x6` and issues them one at a time to the downstream element-wise or multiply stage. It uses a valid/ready handshake. While a frame is in flight it tells the image source to hold the 10x12 image stable, then signals completion. It sits between the combinational tile-extraction transform and the per-tile Winograd engine.

## Interface
- `DATA_WIDTH`, 32: width of one tile element.
- `TILES_R`, 3: tile rows in the grid.
- `TILES_C`, 3: tile columns in the grid.
- `TILE`, 6: tile edge length.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to schedule one frame; honoured only in IDLE.
- `tile_in`  in  `[TILES_R][TILES_C][TILE][TILE]` x `DATA_WIDTH`  all tiles from the transform.
- `tile_data`  out  `[TILE][TILE]` x `DATA_WIDTH`  registered tile currently offered.
- `tile_row`  out  `$clog2(TILES_R)`  grid row of `tile_data`.
- `tile_col`  out  `$clog2(TILES_C)`  grid column of `tile_data`.
- `tile_valid`  out  1  `tile_data`, `tile_row` and `tile_col` are valid.
- `tile_ready`  in  1  the downstream stage accepts the tile.
- `tile_last`  out  1  the offered tile is the final tile (`TILES_R-1`, `TILES_C-1`).
- `image_lock`  out  1  the image source must hold the image unchanged.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse after the last tile is accepted.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - On `start`, capture `tile_in[0][0]` into `tile_data` and set `tile_row` = 0, `tile_col` = 0.
  - Assert `tile_valid`, `busy` and `image_lock`, then go to SEND.
  - If `start` is low, stay in IDLE.
- SEND:
  - A beat is accepted when `tile_valid && tile_ready`.
  - On an accepted non-last beat, advance row-major: increment `tile_col`; on wrap to 0, increment `tile_row`. Capture the new `tile_in[row][col]` in the same edge. `tile_valid` stays high, so back-to-back beats run at full throughput.
  - On an accepted last beat, deassert `tile_valid`, assert `done` and go to DONE.
  - With no handshake, all outputs hold their values. `tile_data` must not change while `tile_valid && !tile_ready`.
- DONE:
  - `done` is high for exactly this one cycle. `busy` and `image_lock` are already low.
  - Go to IDLE unconditionally; `start` is ignored here.
- `start` arriving in SEND or DONE is dropped. It is not queued.
- `tile_last` is combinational: `tile_valid && tile_row == TILES_R-1 && tile_col == TILES_C-1`.
- `busy` = `image_lock` = (state == SEND).
- Data is a pure copy. No arithmetic and no width change; elements are passed bit-exact.
- Reset, including mid-frame: state goes to IDLE immediately (asynchronous). Reset values:
  - `tile_valid`, `busy`, `image_lock`, `done`, `tile_last` = 0.
  - `tile_row`, `tile_col` = 0.
  - `tile_data` = all zeros.
  - The partial frame is abandoned and no `done` is produced.

## Timing
- With `start` sampled at edge N:
  - `tile_valid` = 1 and tile (0,0) are present after edge N.
  - `image_lock` rises after edge N.
- With `tile_ready` held high, beat k is accepted at edge N+1+k for k = 0..8.
- `done` is high between edge N+9 and edge N+10. The earliest next `start` is sampled at edge N+10.
- Frame latency is 10 cycles from `start` to `done` with no backpressure. Each stalled cycle adds exactly one cycle.
- `tile_in` is sampled only at capture edges. The image must be stable from the `start` edge until `image_lock` falls.

## Test plan
- **Sequential image:** drive the image with value i*12+j+1 through the transform, pulse `start`, hold `tile_ready` = 1. Expect 9 beats with (row, col) = (0,0), (0,1) … (2,2). Each `tile_data` must equal the transform's `tile_out` for that tile; zero padding must appear in tiles (0,2), (2,x) and (x,2). `tile_last` must be high only on (2,2). `done` must come 10 cycles after `start`.
- **Backpressure:** deassert `tile_ready` for 3 cycles on beat (1,1). `tile_data` and `tile_row`/`tile_col` must hold for those cycles and no beat may be skipped or duplicated. `done` must come at 13 cycles.
- **Ignored start:** pulse `start` in the middle of SEND and again during DONE. Exactly one frame of 9 beats and one `done` pulse must result. A later `start` in IDLE must begin a fresh frame at (0,0).
- **Reset mid-frame:** assert `rst` after beat (1,0) is accepted. Before the next clock edge, all outputs must read their reset values. There must be no `done`. A new `start` must restart at (0,0).
- **Constant image:** use an all-50 image. Tile (2,2) must show 50 in the in-image positions and 0 in the padding positions. `image_lock` must be high for exactly the SEND cycles.
